// File: rtl/uart_rx_fifo.sv
// UART receive-side capture FSM feeding a first-word-fall-through FIFO.
// Acknowledges every received byte and flags a sticky overrun on drops.
module uart_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx_rdy,
   input  logic [7:0]      rx_data,
   output logic            rx_rdy_clr,
   input  logic            rd_en,
   output logic [7:0]      rd_data,
   output logic            empty,
   output logic            full,
   output logic [ADDR_W:0] count,
   output logic            overrun,
   input  logic            ovr_clr
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      CLR  = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              push_req, do_push, do_pop, drop;

   assign push_req = (state == IDLE) && rx_rdy;
   assign do_pop   = rd_en && !empty;
   // A full FIFO still accepts when the host frees a slot on the same edge
   assign do_push  = push_req && (!full || do_pop);
   assign drop     = push_req && full && !rd_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (rx_rdy) state_nxt = CLR;
         CLR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_rdy_clr = (state == CLR);
      empty      = (count == '0);
      full       = (count == FULL_CNT);
      rd_data    = empty ? 8'h00 : mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // set wins over a coincident clear
         if (drop)         overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
      end
   end

endmodule
